bpu_update_unit: RTL and testbench

- Write-side companion of the gshare direction predictor. It turns resolved-branch outcomes from the execute stage into PHT counter updates and GHR shift requests.
- It buffers resolutions while the BPU is stalled.
- It forwards recently written counter values so that back-to-back branches to the same PHT index never update from a stale counter.
- Its outputs drive the predictor's PHT_Write_Index/Data/En and GHR_Write_Data/En inputs directly.

---
 rtl/bpu_update_unit.sv | 152 +++++++++++++++
 tb/tb_bpu_update_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bpu_update_unit.sv
// Write side of the gshare predictor: buffers resolved branches and turns them
// into PHT counter updates and GHR shifts, forwarding recent counters by index.
module bpu_update_unit #(
  parameter int PHT_IDX_W   = 11,
  parameter int QUEUE_DEPTH = 4,
  parameter int FWD_DEPTH   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EX__Resolve_Valid,
  input  logic                 EX__Resolve_Taken,
  input  logic [PHT_IDX_W-1:0] EX__PHT_Index,
  input  logic [1:0]           EX__PHT_Counter,
  input  logic                 BPU__Stall,
  output logic                 Resolve_Ready,
  output logic                 Update_Dropped,
  output logic [PHT_IDX_W-1:0] PHT_Write_Index,
  output logic [1:0]           PHT_Write_Data,
  output logic                 PHT_Write_En,
  output logic                 GHR_Write_Data,
  output logic                 GHR_Write_En
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  typedef struct packed {
    logic [PHT_IDX_W-1:0] idx;
    logic [1:0]           ctr;
    logic                 taken;
  } entry_t;

  typedef struct packed {
    logic                 v;
    logic [PHT_IDX_W-1:0] idx;
    logic [1:0]           data;
  } fwd_t;

  entry_t q_mem [QUEUE_DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  fwd_t                 fwd_q [FWD_DEPTH];
  fwd_t                 fwd_d [FWD_DEPTH];
  logic [PHT_IDX_W-1:0] pht_idx_q, pht_idx_d;
  logic [1:0]           pht_data_q, pht_data_d;
  logic                 wr_en_q, wr_en_d;
  logic                 ghr_data_q, ghr_data_d;
  logic                 drop_q, drop_d;

  entry_t in_entry, iss_entry;
  logic   ready, accept, have_head, pop, push, bypass, issue;
  logic [1:0] old_ctr, new_ctr;

  assign ready = (count_q != CNT_W'(QUEUE_DEPTH));

  always_comb begin
    in_entry  = '{idx: EX__PHT_Index, ctr: EX__PHT_Counter, taken: EX__Resolve_Taken};
    have_head = (count_q != '0);
    accept    = EX__Resolve_Valid && ready;
    pop       = !BPU__Stall && have_head;
    bypass    = !BPU__Stall && !have_head && accept;
    push      = accept && !bypass;
    issue     = pop || bypass;
    iss_entry = have_head ? q_mem[rd_ptr_q] : in_entry;
    drop_d    = EX__Resolve_Valid && !ready;
  end

  // Walk oldest to youngest so the youngest matching write overrides.
  always_comb begin
    old_ctr = iss_entry.ctr;
    for (int unsigned i = 0; i < FWD_DEPTH; i++) begin
      if (fwd_q[FWD_DEPTH-1-i].v && (fwd_q[FWD_DEPTH-1-i].idx == iss_entry.idx))
        old_ctr = fwd_q[FWD_DEPTH-1-i].data;
    end
    if (iss_entry.taken)
      new_ctr = (old_ctr == 2'b11) ? 2'b11 : old_ctr + 2'd1;
    else
      new_ctr = (old_ctr == 2'b00) ? 2'b00 : old_ctr - 2'd1;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // The output register only advances on non-stall cycles, so a pending
  // strobe survives a stall and is replaced on the cycle the predictor takes it.
  always_comb begin
    pht_idx_d  = pht_idx_q;
    pht_data_d = pht_data_q;
    ghr_data_d = ghr_data_q;
    wr_en_d    = wr_en_q;
    fwd_d      = fwd_q;
    if (!BPU__Stall) begin
      wr_en_d = issue;
      if (issue) begin
        pht_idx_d  = iss_entry.idx;
        pht_data_d = new_ctr;
        ghr_data_d = iss_entry.taken;
        fwd_d[0]   = '{v: 1'b1, idx: iss_entry.idx, data: new_ctr};
        for (int unsigned i = 1; i < FWD_DEPTH; i++)
          fwd_d[i] = fwd_q[i-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push)
      q_mem[wr_ptr_q] <= in_entry;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pht_idx_q  <= '0;
      pht_data_q <= '0;
      wr_en_q    <= 1'b0;
      ghr_data_q <= 1'b0;
      drop_q     <= 1'b0;
      for (int unsigned i = 0; i < FWD_DEPTH; i++)
        fwd_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pht_idx_q  <= pht_idx_d;
      pht_data_q <= pht_data_d;
      wr_en_q    <= wr_en_d;
      ghr_data_q <= ghr_data_d;
      drop_q     <= drop_d;
      fwd_q      <= fwd_d;
    end
  end

  assign Resolve_Ready   = ready;
  assign Update_Dropped  = drop_q;
  assign PHT_Write_Index = pht_idx_q;
  assign PHT_Write_Data  = pht_data_q;
  assign PHT_Write_En    = wr_en_q;
  assign GHR_Write_Data  = ghr_data_q;
  assign GHR_Write_En    = wr_en_q;

endmodule

// File: tb/tb_bpu_update_unit.sv
// Directed bench for bpu_update_unit: expected writes go into a scoreboard
// queue and are checked by a monitor whenever the predictor consumes a write.
module tb_bpu_update_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        EX__Resolve_Valid = 1'b0;
  logic        EX__Resolve_Taken = 1'b0;
  logic [10:0] EX__PHT_Index = '0;
  logic [1:0]  EX__PHT_Counter = '0;
  logic        BPU__Stall = 1'b0;
  logic        Resolve_Ready, Update_Dropped;
  logic [10:0] PHT_Write_Index;
  logic [1:0]  PHT_Write_Data;
  logic        PHT_Write_En, GHR_Write_Data, GHR_Write_En;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [10:0] idx;
    logic [1:0]  data;
    logic        ghr;
  } exp_t;
  exp_t exp_q[$];

  bpu_update_unit #(.PHT_IDX_W(11), .QUEUE_DEPTH(4), .FWD_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .EX__Resolve_Valid(EX__Resolve_Valid), .EX__Resolve_Taken(EX__Resolve_Taken),
    .EX__PHT_Index(EX__PHT_Index), .EX__PHT_Counter(EX__PHT_Counter),
    .BPU__Stall(BPU__Stall),
    .Resolve_Ready(Resolve_Ready), .Update_Dropped(Update_Dropped),
    .PHT_Write_Index(PHT_Write_Index), .PHT_Write_Data(PHT_Write_Data),
    .PHT_Write_En(PHT_Write_En), .GHR_Write_Data(GHR_Write_Data),
    .GHR_Write_En(GHR_Write_En)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs applied for one cycle; returns 1 time unit after the closing edge.
  task automatic step(input logic v, input logic t, input logic [10:0] idx,
                      input logic [1:0] ctr, input logic st);
    EX__Resolve_Valid = v;
    EX__Resolve_Taken = t;
    EX__PHT_Index     = idx;
    EX__PHT_Counter   = ctr;
    BPU__Stall        = st;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input logic st);
    step(1'b0, 1'b0, 11'h0, 2'b00, st);
  endtask

  task automatic expect_w(input logic [10:0] idx, input logic [1:0] data, input logic ghr);
    exp_t e;
    e.idx = idx; e.data = data; e.ghr = ghr;
    exp_q.push_back(e);
  endtask

  // A write is consumed on the coming edge when the enable is up and no stall.
  always @(negedge CLK) begin
    if (!RST && PHT_Write_En === 1'b1 && BPU__Stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_idx", {21'h0, PHT_Write_Index}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_idx", {21'h0, PHT_Write_Index}, {21'h0, e.idx});
        chk("wr_data", {30'h0, PHT_Write_Data}, {30'h0, e.data});
        chk("ghr_data", {31'h0, GHR_Write_Data}, {31'h0, e.ghr});
        chk("ghr_en", {31'h0, GHR_Write_En}, 32'h1);
      end
    end
  end

  initial begin
    // Asynchronous reset mid-cycle, then idle
    #3 RST = 1'b1;
    #1;
    chk("rst_pht_en", {31'h0, PHT_Write_En}, 32'h0);
    chk("rst_ghr_en", {31'h0, GHR_Write_En}, 32'h0);
    chk("rst_idx", {21'h0, PHT_Write_Index}, 32'h0);
    chk("rst_data", {30'h0, PHT_Write_Data}, 32'h0);
    chk("rst_ghr_data", {31'h0, GHR_Write_Data}, 32'h0);
    chk("rst_drop", {31'h0, Update_Dropped}, 32'h0);
    chk("rst_ready", {31'h0, Resolve_Ready}, 32'h1);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle(1'b0);
      chk("idle_en", {30'h0, PHT_Write_En, GHR_Write_En}, 32'h0);
      chk("idle_ready", {31'h0, Resolve_Ready}, 32'h1);
    end

    // Single update, one-cycle latency
    expect_w(11'h155, 2'b10, 1'b1);
    step(1'b1, 1'b1, 11'h155, 2'b01, 1'b0);
    chk("single_en", {31'h0, PHT_Write_En}, 32'h1);
    chk("single_idx", {21'h0, PHT_Write_Index}, 32'h155);
    chk("single_data", {30'h0, PHT_Write_Data}, 32'h2);
    chk("single_ghr", {31'h0, GHR_Write_Data}, 32'h1);
    idle(1'b0);
    chk("single_en_off", {30'h0, PHT_Write_En, GHR_Write_En}, 32'h0);

    // Saturation and forwarding on index 0x020
    expect_w(11'h020, 2'b11, 1'b1);
    expect_w(11'h020, 2'b11, 1'b1);
    expect_w(11'h020, 2'b11, 1'b1);
    expect_w(11'h020, 2'b10, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 11'h020, 2'b10, 1'b0);
    step(1'b1, 1'b0, 11'h020, 2'b10, 1'b0);
    chk("fwd_dec_data", {30'h0, PHT_Write_Data}, 32'h2);
    idle(1'b0);

    // Stall buffering: four queue up, fifth dropped
    expect_w(11'h100, 2'b01, 1'b1);
    expect_w(11'h101, 2'b11, 1'b1);
    expect_w(11'h102, 2'b00, 1'b0);
    expect_w(11'h103, 2'b01, 1'b0);
    step(1'b1, 1'b1, 11'h100, 2'b00, 1'b1);
    chk("stall_ready1", {31'h0, Resolve_Ready}, 32'h1);
    step(1'b1, 1'b1, 11'h101, 2'b11, 1'b1);
    step(1'b1, 1'b0, 11'h102, 2'b00, 1'b1);
    chk("stall_ready3", {31'h0, Resolve_Ready}, 32'h1);
    step(1'b1, 1'b0, 11'h103, 2'b10, 1'b1);
    chk("stall_full_ready", {31'h0, Resolve_Ready}, 32'h0);
    chk("stall_no_drop_yet", {31'h0, Update_Dropped}, 32'h0);
    step(1'b1, 1'b1, 11'h104, 2'b01, 1'b1);
    chk("stall_dropped", {31'h0, Update_Dropped}, 32'h1);
    chk("stall_en_held_off", {31'h0, PHT_Write_En}, 32'h0);
    idle(1'b1);
    chk("stall_drop_pulse_end", {31'h0, Update_Dropped}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      chk("drain_en", {30'h0, PHT_Write_En, GHR_Write_En}, 32'h3);
    end
    idle(1'b0);
    chk("drain_done_en", {31'h0, PHT_Write_En}, 32'h0);
    chk("drain_ready", {31'h0, Resolve_Ready}, 32'h1);

    // Pending write held across a 3-cycle stall
    expect_w(11'h200, 2'b10, 1'b1);
    expect_w(11'h201, 2'b00, 1'b0);
    step(1'b1, 1'b1, 11'h200, 2'b01, 1'b0);
    step(1'b1, 1'b0, 11'h201, 2'b01, 1'b1);
    chk("hold1", {18'h0, PHT_Write_En, PHT_Write_Index, PHT_Write_Data}, {18'h0, 1'b1, 11'h200, 2'b10});
    idle(1'b1);
    chk("hold2", {18'h0, PHT_Write_En, PHT_Write_Index, PHT_Write_Data}, {18'h0, 1'b1, 11'h200, 2'b10});
    idle(1'b1);
    chk("hold3", {18'h0, PHT_Write_En, PHT_Write_Index, PHT_Write_Data}, {18'h0, 1'b1, 11'h200, 2'b10});
    idle(1'b0);
    chk("next_after_stall", {18'h0, PHT_Write_En, PHT_Write_Index, PHT_Write_Data}, {18'h0, 1'b1, 11'h201, 2'b00});
    idle(1'b0);

    // Reset mid-operation with a pending write and three queued entries
    step(1'b1, 1'b1, 11'h2F0, 2'b01, 1'b0);
    step(1'b1, 1'b1, 11'h300, 2'b00, 1'b1);
    step(1'b1, 1'b0, 11'h301, 2'b11, 1'b1);
    step(1'b1, 1'b1, 11'h302, 2'b01, 1'b1);
    chk("pre_rst_en", {31'h0, PHT_Write_En}, 32'h1);
    #2 RST = 1'b1;
    EX__Resolve_Valid = 1'b0;
    BPU__Stall = 1'b0;
    #1;
    chk("midrst_en", {30'h0, PHT_Write_En, GHR_Write_En}, 32'h0);
    chk("midrst_ready", {31'h0, Resolve_Ready}, 32'h1);
    @(posedge CLK);
    #1 RST = 1'b0;
    for (int i = 0; i < 6; i++) idle(1'b0);
    chk("post_rst_no_writes", {31'h0, PHT_Write_En}, 32'h0);

    // Forwarding table cleared by reset: 0x020 uses the entry's own counter
    expect_w(11'h020, 2'b01, 1'b1);
    step(1'b1, 1'b1, 11'h020, 2'b00, 1'b0);
    chk("post_rst_fwd_data", {30'h0, PHT_Write_Data}, 32'h1);
    idle(1'b0);
    idle(1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge CLK);
    chk("scoreboard_empty", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
